// File: rtl/jtag_instruction_register.sv
// ---------------------------------------------------------------------------
// jtag_instruction_register
//
// JTAG instruction register with a registered opcode decoder. It holds the
// IR shift stage (capture/shift), the update (parallel) stage and the decode
// that selects the test data register. Unknown opcodes, and AHB opcodes
// while debug is locked, fall back to BYPASS and flag illegal_instr.
// CLAMP_HOLD / CLAMP_RELEASE drive a sticky clamp state.
//
// Ports:
//   TCK                   test clock; all state changes on its rising edge
//   TRST                  synchronous active-high reset
//   test_logic_reset      TAP in Test-Logic-Reset; same effect as TRST
//   capture_ir            Capture-IR strobe (loads CAPTURE_PATTERN)
//   shift_ir              Shift-IR strobe (shifts tdi in at the MSB)
//   update_ir             Update-IR strobe (latches and decodes the IR)
//   tdi                   serial data in
//   ahb_enable            debug unlock; 0 turns AHB opcodes into BYPASS
//   ir_tdo                serial data out (sr[0])
//   instr                 effective latched instruction
//   bsr_select, bsr_mode, id_select, bypass_select, tmp_select,
//   ahb_select, ahb_fifo_read_select   registered decode outputs
//   clamp_active          sticky clamp state
//   illegal_instr         last update was unknown or locked
// ---------------------------------------------------------------------------
module jtag_instruction_register #(
  parameter int unsigned         IR_WIDTH         = 5,
  parameter logic [IR_WIDTH-1:0] CAPTURE_PATTERN  = 5'b00001,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST        = 5'h00,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE        = 5'h01,
  parameter logic [IR_WIDTH-1:0] OP_PRELOAD       = 5'h02,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE        = 5'h03,
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_HOLD    = 5'h04,
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_RELEASE = 5'h05,
  parameter logic [IR_WIDTH-1:0] OP_AHB           = 5'h10,
  parameter logic [IR_WIDTH-1:0] OP_AHB_READ      = 5'h11,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS        = {IR_WIDTH{1'b1}}
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                test_logic_reset,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                tdi,
  input  logic                ahb_enable,
  output logic                ir_tdo,
  output logic [IR_WIDTH-1:0] instr,
  output logic                bsr_select,
  output logic                bsr_mode,
  output logic                id_select,
  output logic                bypass_select,
  output logic                tmp_select,
  output logic                ahb_select,
  output logic                ahb_fifo_read_select,
  output logic                clamp_active,
  output logic                illegal_instr
);

  // Select vector bit positions.
  localparam int unsigned S_BSR    = 0;
  localparam int unsigned S_MODE   = 1;
  localparam int unsigned S_ID     = 2;
  localparam int unsigned S_BYPASS = 3;
  localparam int unsigned S_TMP    = 4;
  localparam int unsigned S_AHB    = 5;
  localparam int unsigned S_FIFO   = 6;

  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [6:0]          sel_q, sel_d;
  logic                clamp_q, clamp_d;
  logic                illegal_q, illegal_d;

  logic [IR_WIDTH-1:0] eff_instr;
  logic                eff_illegal;
  logic [6:0]          eff_sel;
  logic                raw_known;
  logic                raw_locked;

  // Remap the shifted opcode: unknown or locked opcodes become BYPASS.
  always_comb begin
    raw_known = (sr_q == OP_EXTEST)     || (sr_q == OP_SAMPLE)        ||
                (sr_q == OP_PRELOAD)    || (sr_q == OP_IDCODE)        ||
                (sr_q == OP_CLAMP_HOLD) || (sr_q == OP_CLAMP_RELEASE) ||
                (sr_q == OP_AHB)        || (sr_q == OP_AHB_READ)      ||
                (sr_q == OP_BYPASS);
    raw_locked = ((sr_q == OP_AHB) || (sr_q == OP_AHB_READ)) && !ahb_enable;
    if (raw_known && !raw_locked) begin
      eff_instr   = sr_q;
      eff_illegal = 1'b0;
    end else begin
      eff_instr   = OP_BYPASS;
      eff_illegal = 1'b1;
    end
  end

  // Decode the effective opcode into exactly one select class.
  always_comb begin
    eff_sel = 7'b0000000;
    case (eff_instr)
      OP_EXTEST: begin
        eff_sel[S_BSR]  = 1'b1;
        eff_sel[S_MODE] = 1'b1;
      end
      OP_SAMPLE, OP_PRELOAD:           eff_sel[S_BSR]    = 1'b1;
      OP_IDCODE:                       eff_sel[S_ID]     = 1'b1;
      OP_AHB:                          eff_sel[S_AHB]    = 1'b1;
      OP_AHB_READ:                     eff_sel[S_FIFO]   = 1'b1;
      OP_CLAMP_HOLD, OP_CLAMP_RELEASE: eff_sel[S_TMP]    = 1'b1;
      OP_BYPASS:                       eff_sel[S_BYPASS] = 1'b1;
      // eff_instr is always a known opcode; fall back to BYPASS regardless.
      default:                         eff_sel[S_BYPASS] = 1'b1;
    endcase
  end

  // Next-state logic; update outranks capture, which outranks shift.
  always_comb begin
    sr_d      = sr_q;
    instr_d   = instr_q;
    sel_d     = sel_q;
    clamp_d   = clamp_q;
    illegal_d = illegal_q;
    if (update_ir) begin
      instr_d   = eff_instr;
      sel_d     = eff_sel;
      illegal_d = eff_illegal;
      if (eff_instr == OP_CLAMP_HOLD) begin
        clamp_d = 1'b1;
      end else if (eff_instr == OP_CLAMP_RELEASE) begin
        clamp_d = 1'b0;
      end else begin
        clamp_d = clamp_q;
      end
    end else if (capture_ir) begin
      sr_d = CAPTURE_PATTERN;
    end else if (shift_ir) begin
      sr_d = {tdi, sr_q[IR_WIDTH-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  // State registers with synchronous reset to the IDCODE instruction.
  always_ff @(posedge TCK) begin
    if (TRST || test_logic_reset) begin
      sr_q      <= CAPTURE_PATTERN;
      instr_q   <= OP_IDCODE;
      sel_q     <= 7'b0000100;
      clamp_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      instr_q   <= instr_d;
      sel_q     <= sel_d;
      clamp_q   <= clamp_d;
      illegal_q <= illegal_d;
    end
  end

  assign ir_tdo               = sr_q[0];
  assign instr                = instr_q;
  assign bsr_select           = sel_q[S_BSR];
  assign bsr_mode             = sel_q[S_MODE];
  assign id_select            = sel_q[S_ID];
  assign bypass_select        = sel_q[S_BYPASS];
  assign tmp_select           = sel_q[S_TMP];
  assign ahb_select           = sel_q[S_AHB];
  assign ahb_fifo_read_select = sel_q[S_FIFO];
  assign clamp_active         = clamp_q;
  assign illegal_instr        = illegal_q;

endmodule

// File: tb/tb_jtag_instruction_register.sv
// ---------------------------------------------------------------------------
// tb_jtag_instruction_register
//
// Scoreboard bench: expected values are pushed when stimulus is driven and
// popped when the DUT output is sampled (1 time unit after the TCK edge).
// Output vector layout: {instr[4:0], bsr_select, bsr_mode, id_select,
// bypass_select, tmp_select, ahb_select, ahb_fifo_read_select,
// clamp_active, illegal_instr}.
// ---------------------------------------------------------------------------
module tb_jtag_instruction_register;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       test_logic_reset = 1'b0;
  logic       capture_ir = 1'b0;
  logic       shift_ir = 1'b0;
  logic       update_ir = 1'b0;
  logic       tdi = 1'b0;
  logic       ahb_enable = 1'b0;
  logic       ir_tdo;
  logic [4:0] instr;
  logic       bsr_select, bsr_mode, id_select, bypass_select, tmp_select;
  logic       ahb_select, ahb_fifo_read_select, clamp_active, illegal_instr;

  jtag_instruction_register dut (
    .TCK                  (TCK),
    .TRST                 (TRST),
    .test_logic_reset     (test_logic_reset),
    .capture_ir           (capture_ir),
    .shift_ir             (shift_ir),
    .update_ir            (update_ir),
    .tdi                  (tdi),
    .ahb_enable           (ahb_enable),
    .ir_tdo               (ir_tdo),
    .instr                (instr),
    .bsr_select           (bsr_select),
    .bsr_mode             (bsr_mode),
    .id_select            (id_select),
    .bypass_select        (bypass_select),
    .tmp_select           (tmp_select),
    .ahb_select           (ahb_select),
    .ahb_fifo_read_select (ahb_fifo_read_select),
    .clamp_active         (clamp_active),
    .illegal_instr        (illegal_instr)
  );

  // Free-running test clock.
  always #5 TCK = ~TCK;

  typedef struct {
    string       tag;
    logic [13:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_clamp = 1'b0;
  logic [13:0] cur_exp;
  logic [4:0]  cap_pat = 5'b00001;

  localparam logic [13:0] RESET_VEC = {5'h03, 9'b001000000};

  task automatic check_val(input string tag, input logic [13:0] obs,
                           input logic [13:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] obs_vec();
    return {instr, bsr_select, bsr_mode, id_select, bypass_select, tmp_select,
            ahb_select, ahb_fifo_read_select, clamp_active, illegal_instr};
  endfunction

  task automatic sb_push(input string tag, input logic [13:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [13:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", obs, 14'h3fff ^ obs);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // Reference model of one update: remap, decode and clamp tracking.
  task automatic model_update(input logic [4:0] raw, input logic en,
                              output logic [13:0] v);
    logic [4:0] eff;
    logic       ill;
    logic [6:0] s; // bsr, mode, id, bypass, tmp, ahb, fifo
    if ((raw inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h1F}) ||
        (en && (raw inside {5'h10, 5'h11}))) begin
      eff = raw;
      ill = 1'b0;
    end else begin
      eff = 5'h1F;
      ill = 1'b1;
    end
    if (eff == 5'h00)                       s = 7'b1100000;
    else if (eff == 5'h01 || eff == 5'h02)  s = 7'b1000000;
    else if (eff == 5'h03)                  s = 7'b0010000;
    else if (eff == 5'h04 || eff == 5'h05)  s = 7'b0000100;
    else if (eff == 5'h10)                  s = 7'b0000010;
    else if (eff == 5'h11)                  s = 7'b0000001;
    else                                    s = 7'b0001000;
    if (eff == 5'h04)      m_clamp = 1'b1;
    else if (eff == 5'h05) m_clamp = 1'b0;
    v = {eff, s, m_clamp, ill};
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset(input bit use_tlr);
    if (use_tlr) test_logic_reset = 1'b1;
    else         TRST = 1'b1;
    m_clamp = 1'b0;
    cur_exp = RESET_VEC;
    sb_push("reset_outs", RESET_VEC);
    sb_push("reset_tdo", 14'd1);
    tick();
    TRST = 1'b0;
    test_logic_reset = 1'b0;
    sb_pop(obs_vec());
    sb_pop({13'd0, ir_tdo});
  endtask

  task automatic capture_shift(input logic [4:0] raw);
    capture_ir = 1'b1;
    sb_push("cap_tdo", {13'd0, cap_pat[0]});
    tick();
    capture_ir = 1'b0;
    sb_pop({13'd0, ir_tdo});
    for (int i = 0; i < 5; i++) begin
      tdi = raw[i];
      shift_ir = 1'b1;
      sb_push($sformatf("shift_tdo_%0d", i),
              {13'd0, (i < 4) ? cap_pat[i+1] : raw[0]});
      tick();
      sb_pop({13'd0, ir_tdo});
    end
    shift_ir = 1'b0;
    tdi = 1'b0;
    sb_push("hold_during_shift", cur_exp);
    sb_pop(obs_vec());
  endtask

  task automatic load_ir(input logic [4:0] raw, input string tag);
    capture_shift(raw);
    update_ir = 1'b1;
    model_update(raw, ahb_enable, cur_exp);
    sb_push(tag, cur_exp);
    tick();
    update_ir = 1'b0;
    sb_pop(obs_vec());
  endtask

  initial begin
    tick();
    do_reset(1'b0);

    load_ir(5'h00, "extest");
    load_ir(5'h0A, "unknown_0a");
    load_ir(5'h01, "sample");

    ahb_enable = 1'b0;
    load_ir(5'h10, "ahb_locked");
    ahb_enable = 1'b1;
    load_ir(5'h10, "ahb_unlocked");
    load_ir(5'h11, "ahb_read");
    ahb_enable = 1'b0;
    sb_push("ahb_read_held", cur_exp);
    tick();
    sb_pop(obs_vec());
    ahb_enable = 1'b1;

    load_ir(5'h1F, "bypass");
    load_ir(5'h04, "clamp_hold");
    load_ir(5'h01, "clamp_sticky");
    load_ir(5'h03, "idcode");
    load_ir(5'h05, "clamp_release");
    load_ir(5'h04, "clamp_hold2");
    do_reset(1'b1);

    // update and capture together: update wins, sr keeps 5'h02
    capture_shift(5'h02);
    update_ir = 1'b1;
    capture_ir = 1'b1;
    model_update(5'h02, ahb_enable, cur_exp);
    sb_push("upd_cap_outs", cur_exp);
    sb_push("upd_cap_tdo", 14'd0);
    tick();
    update_ir = 1'b0;
    capture_ir = 1'b0;
    sb_pop(obs_vec());
    sb_pop({13'd0, ir_tdo});
    tdi = 1'b0;
    shift_ir = 1'b1;
    sb_push("upd_cap_sr1", 14'd1);
    tick();
    shift_ir = 1'b0;
    sb_pop({13'd0, ir_tdo});

    // reset mid-shift
    load_ir(5'h04, "pre_midshift");
    capture_ir = 1'b1;
    tick();
    capture_ir = 1'b0;
    tdi = 1'b1;
    shift_ir = 1'b1;
    tick();
    tick();
    TRST = 1'b1;
    m_clamp = 1'b0;
    cur_exp = RESET_VEC;
    sb_push("midshift_reset_outs", RESET_VEC);
    sb_push("midshift_reset_tdo", 14'd1);
    tick();
    TRST = 1'b0;
    sb_pop(obs_vec());
    sb_pop({13'd0, ir_tdo});
    tdi = 1'b0;
    sb_push("midshift_sr_bit1", 14'd0);
    tick();
    shift_ir = 1'b0;
    sb_pop({13'd0, ir_tdo});

    if (sb_q.size() != 0) begin
      check_val("sb_leftover", 14'(sb_q.size()), 14'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
